dbgregs: RTL

DBGREGS -- requirements
Module: dbgregs

---
 rtl/dbgregs.sv | 97 +++++++++
 1 files changed

// File: rtl/dbgregs.sv
// dbgregs: debug-port register file with optional frame-synchronous shadowing (DBGREGS_SHADOW_EN)
module dbgregs (
    input  logic        clk,
    input  logic        reset,
    input  logic [7:0]  dbgaddr,
    input  logic [7:0]  dbgwdata,
    input  logic        dbgreq,
    output logic        dbgack,
    input  logic        frame,
    output logic [15:0] hscale,
    output logic [15:0] vscale,
    output logic [11:0] xoff,
    output logic [11:0] yoff,
    output logic [7:0]  ctrl,
    output logic        pending
);
    typedef enum logic [2:0] {IDLE, SETTLE, WRITE, ACK, DRAIN} state_t;
    state_t      state;
    logic        settle_cnt;
    logic        wr;
    logic [15:0] s_h, s_v;
    logic [11:0] s_x, s_y;
    logic [7:0]  s_c;
    assign wr = (state == WRITE);
    // request handshake: two settle cycles, one write, one ack pulse, then wait for dbgreq to drop
    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= IDLE;
            settle_cnt <= 1'b0;
            dbgack     <= 1'b0;
        end else begin
            case (state)
                IDLE:    if (dbgreq) begin state <= SETTLE; settle_cnt <= 1'b0; end
                SETTLE:  if (settle_cnt) state <= WRITE; else settle_cnt <= 1'b1;
                WRITE:   begin state <= ACK; dbgack <= 1'b1; end
                ACK:     begin state <= DRAIN; dbgack <= 1'b0; end
                DRAIN:   if (!dbgreq) state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end
    // register write; these are staging registers when shadowing, else the live outputs
    always_ff @(posedge clk) begin
        if (reset) begin
            s_h <= 16'h0100;
            s_v <= 16'h0100;
            s_x <= 12'h000;
            s_y <= 12'h000;
            s_c <= 8'h00;
        end else if (wr) begin
            case (dbgaddr)
                8'h00:   s_h[7:0]  <= dbgwdata;
                8'h01:   s_h[15:8] <= dbgwdata;
                8'h02:   s_v[7:0]  <= dbgwdata;
                8'h03:   s_v[15:8] <= dbgwdata;
                8'h04:   s_x[7:0]  <= dbgwdata;
                8'h05:   s_x[11:8] <= dbgwdata[3:0];
                8'h06:   s_y[7:0]  <= dbgwdata;
                8'h07:   s_y[11:8] <= dbgwdata[3:0];
                8'h08:   s_c       <= dbgwdata;
                default: ;
            endcase
        end
    end
`ifdef DBGREGS_SHADOW_EN
    // frame copy uses pre-write staging; a commit in the frame cycle survives for the next frame
    always_ff @(posedge clk) begin
        if (reset) begin
            hscale  <= 16'h0100;
            vscale  <= 16'h0100;
            xoff    <= 12'h000;
            yoff    <= 12'h000;
            ctrl    <= 8'h00;
            pending <= 1'b0;
        end else begin
            if (frame && pending) begin
                hscale  <= s_h;
                vscale  <= s_v;
                xoff    <= s_x;
                yoff    <= s_y;
                ctrl    <= s_c;
                pending <= 1'b0;
            end
            if (wr && dbgaddr == 8'h0F) pending <= 1'b1;
        end
    end
`else
    logic unused_frame;
    assign unused_frame = frame;
    assign hscale  = s_h;
    assign vscale  = s_v;
    assign xoff    = s_x;
    assign yoff    = s_y;
    assign ctrl    = s_c;
    assign pending = 1'b0;
`endif
endmodule
